// File: rtl/seq_div.sv
// seq_div: fixed-latency restoring divider, one quotient bit per clock.
// Latency from the accepting edge to valid is WIDTH+1 cycles, independent of operand values.
// Optional feature: define DIV_SIGNED_EN for two's-complement operands with truncating
// division. Without it, operands are unsigned and no sign logic is built.
module seq_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div0
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    // Control state
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Datapath state. The partial remainder is conceptually WIDTH+1 bits, but its top bit
    // is provably zero after every iteration (R < D), so only WIDTH bits are stored.
    logic [WIDTH-1:0] rem_part_q, rem_part_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             zero_q, zero_d;
`ifdef DIV_SIGNED_EN
    logic             neg_dvd_q, neg_dvd_d;
    logic             neg_dvs_q, neg_dvs_d;
`endif

    // Result registers
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div0_q, div0_d;

    logic             accept;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   trial_shift;
    logic [WIDTH:0]   trial_diff;

    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

    // Operand magnitudes taken on capture
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
`ifdef DIV_SIGNED_EN
        if (dividend[WIDTH-1]) dvd_mag = ~dividend + One;
        if (divisor[WIDTH-1])  dvs_mag = ~divisor + One;
`endif
    end

    // One restoring step: shift in the next dividend bit and try to subtract the divisor
    always_comb begin
        trial_shift = {rem_part_q, shift_q[WIDTH-1]};
        trial_diff  = trial_shift - {1'b0, dvs_q};
    end

    // Next-state and iteration counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCalc;
                    cnt_d   = CntLoad;
                end
            end
            StCalc: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) state_d = StFix;
            end
            StFix: begin
                state_d = StDone;
            end
            StDone: begin
                if (accept) begin
                    state_d = StCalc;
                    cnt_d   = CntLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operand capture and shift/subtract datapath
    always_comb begin
        rem_part_d = rem_part_q;
        shift_d    = shift_q;
        dvs_d      = dvs_q;
        zero_d     = zero_q;
`ifdef DIV_SIGNED_EN
        neg_dvd_d  = neg_dvd_q;
        neg_dvs_d  = neg_dvs_q;
`endif
        if (accept) begin
            rem_part_d = '0;
            shift_d    = dvd_mag;
            dvs_d      = dvs_mag;
            zero_d     = (divisor == '0);
`ifdef DIV_SIGNED_EN
            neg_dvd_d  = dividend[WIDTH-1];
            neg_dvs_d  = divisor[WIDTH-1];
`endif
        end else if (state_q == StCalc) begin
            if (trial_diff[WIDTH]) begin
                // Subtraction would go negative: restore and shift in a 0
                rem_part_d = trial_shift[WIDTH-1:0];
                shift_d    = {shift_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_part_d = trial_diff[WIDTH-1:0];
                shift_d    = {shift_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Final sign adjustment and divide-by-zero override, loaded on the FIX->DONE edge
    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        div0_d = div0_q;
        if (state_q == StFix) begin
            quot_d = shift_q;
            rem_d  = rem_part_q;
`ifdef DIV_SIGNED_EN
            if (neg_dvd_q ^ neg_dvs_q) quot_d = ~shift_q + One;
            if (neg_dvd_q)             rem_d  = ~rem_part_q + One;
`endif
            // With a zero divisor every step succeeds, so the quotient is all ones and the
            // remainder is the dividend magnitude; the sign restore above turns that back
            // into the original dividend. The quotient is forced so the sign rule cannot
            // touch it.
            if (zero_q) quot_d = '1;
            div0_d = zero_q;
        end
    end

    // Control registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_part_q <= '0;
            shift_q    <= '0;
            dvs_q      <= '0;
            zero_q     <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_dvd_q  <= 1'b0;
            neg_dvs_q  <= 1'b0;
`endif
        end else begin
            rem_part_q <= rem_part_d;
            shift_q    <= shift_d;
            dvs_q      <= dvs_d;
            zero_q     <= zero_d;
`ifdef DIV_SIGNED_EN
            neg_dvd_q  <= neg_dvd_d;
            neg_dvs_q  <= neg_dvs_d;
`endif
        end
    end

    // Result registers, held between divisions
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            div0_q <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            div0_q <= div0_d;
        end
    end

    assign busy  = (state_q == StCalc) || (state_q == StFix);
    assign valid = (state_q == StDone);
    assign quot  = quot_q;
    assign rem   = rem_q;
    assign div0  = div0_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized self-checking bench for seq_div against an arithmetic reference.
// Follows the DUT build: define DIV_SIGNED_EN for both to exercise the signed variant.
module tb_seq_div;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         valid;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div0;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div #(.WIDTH(W)) dut (
        .clock    (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .valid    (valid),
        .quot     (quot),
        .rem      (rem),
        .div0     (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain language-level division with the zero-divisor convention on top
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        longint sa;
        longint sb;
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
`else
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
`endif
            // Truncating division; most-negative / -1 wraps to most-negative in W bits
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full division from an idle DUT; called at 1 time unit after a rising edge
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           n;
        int           nb;
        model(a, b, eq, er, ez);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check_eq("busy_after_accept", {63'd0, busy}, 64'd1);
        n  = 0;
        nb = 0;
        while (!valid && n < 200) begin
            tick();
            n++;
            if (!valid && busy) nb++;
        end
        check_eq("latency", 64'(n), 64'(W + 1));
        check_eq("busy_cycles", 64'(nb), 64'(W));
        check_eq("quot", {32'd0, quot}, {32'd0, eq});
        check_eq("rem", {32'd0, rem}, {32'd0, er});
        check_eq("div0", {63'd0, div0}, {63'd0, ez});
        tick();
        check_eq("valid_one_cycle", {63'd0, valid}, 64'd0);
        check_eq("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           n;
        int           nv;

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) tick();
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_valid", {63'd0, valid}, 64'd0);
        check_eq("rst_quot", {32'd0, quot}, 64'd0);
        check_eq("rst_rem", {32'd0, rem}, 64'd0);
        check_eq("rst_div0", {63'd0, div0}, 64'd0);
        reset_n = 1'b1;
        tick();
        check_eq("idle_valid", {63'd0, valid}, 64'd0);

        // Directed cases
        do_div(32'd100, 32'd7);
        do_div(32'hFFFFFF9C, 32'd7);
        do_div(32'd5, 32'd0);
        do_div(32'h80000000, 32'hFFFFFFFF);
        do_div(32'hFFFFFF9C, 32'd0);

        // start held through CALC/FIX with changing operands, then 9/2 presented in DONE
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        tick();
        for (int i = 1; i <= int'(W); i++) begin
            dividend = $urandom;
            divisor  = $urandom | 32'd1;
            start    = 1'b1;
            tick();
        end
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        tick();
        model(32'd100, 32'd7, eq, er, ez);
        check_eq("hold_valid", {63'd0, valid}, 64'd1);
        check_eq("hold_quot", {32'd0, quot}, {32'd0, eq});
        check_eq("hold_rem", {32'd0, rem}, {32'd0, er});
        n = 0;
        tick();
        n++;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check_eq("b2b_busy", {63'd0, busy}, 64'd1);
        while (!valid && n < 200) begin
            tick();
            n++;
        end
        check_eq("b2b_spacing", 64'(n), 64'(W + 2));
        check_eq("b2b_quot", {32'd0, quot}, 64'd4);
        check_eq("b2b_rem", {32'd0, rem}, 64'd1);
        tick();
        check_eq("b2b_valid_drop", {63'd0, valid}, 64'd0);

        // Asynchronous reset in the middle of CALC
        start    = 1'b1;
        dividend = 32'hFFFFFFFF;
        divisor  = 32'h10;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        check_eq("arst_busy", {63'd0, busy}, 64'd0);
        check_eq("arst_valid", {63'd0, valid}, 64'd0);
        check_eq("arst_quot", {32'd0, quot}, 64'd0);
        check_eq("arst_rem", {32'd0, rem}, 64'd0);
        check_eq("arst_div0", {63'd0, div0}, 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid || busy) nv++;
        end
        check_eq("arst_no_result", 64'(nv), 64'd0);
        do_div(32'hFFFFFFFF, 32'h10);

        // Randomized operands with biased divisor classes
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                3: begin
                    a = 32'h80000000;
                    b = $urandom;
                end
                4:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_div(a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Fixed-latency iterative divider: restoring shift/subtract, one quotient bit per clock.
- Companion to the shift/add multiplier; lives in the same arithmetic block and uses the same start/valid style.
- Produces quotient, remainder and a divide-by-zero flag after a fixed latency independent of operand values.
- Signed operation is a compile-time option.

Parameters:
WIDTH  32  operand/result width in bits (dividend, divisor, quotient, remainder); legal values >= 4

Ports:
clock     input   1      rising-edge clock
reset_n   input   1      asynchronous active-low reset
start     input   1      request; accepted only in IDLE or DONE
dividend  input   WIDTH  dividend; sampled on the accepting edge only
divisor   input   WIDTH  divisor; sampled on the accepting edge only
busy      output  1      high in CALC and FIX
valid     output  1      one-cycle pulse, high only in DONE
quot      output  WIDTH  quotient; updated on the FIX->DONE edge, held otherwise
rem       output  WIDTH  remainder; updated on the FIX->DONE edge, held otherwise
div0      output  1      divisor was zero; updated and held with quot/rem

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, busy=0, valid=0, quot=0, rem=0, div0=0.
  - Internal counter, shift and remainder registers are cleared.
  - Reset mid-operation abandons the division; no valid is produced.
- Operand capture: on the accepting edge, latch the magnitudes of dividend and divisor, their sign bits and the divisor==0 flag. Inputs may change freely afterwards.
- States:
  - IDLE: start=1 -> CALC.
  - CALC: exactly WIDTH cycles, counted by a clog2(WIDTH+1)-bit counter, then -> FIX.
  - FIX: exactly 1 cycle, then -> DONE.
  - DONE: exactly 1 cycle. start=1 -> CALC (back-to-back); otherwise -> IDLE.
- start in CALC or FIX is ignored, not queued.
- Latency: if start is accepted on edge k, DONE (valid=1) holds from edge k+WIDTH+1 until edge k+WIDTH+2. Throughput is one result per WIDTH+2 cycles.
- CALC iteration, using a (WIDTH+1)-bit partial remainder R, a WIDTH-bit shift register Q and divisor magnitude D:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}.
  - If T is negative (MSB=1): R = {R[WIDTH-1:0], Q[WIDTH-1]}, Q = {Q[WIDTH-2:0], 0}.
  - Else: R = T, Q = {Q[WIDTH-2:0], 1}.
- FIX (sign adjust and special cases), results registered on the FIX->DONE edge:
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when the dividend is negative, giving truncating division (sign of rem = sign of dividend).
  - Divisor==0: quot = all ones, rem = original dividend, div0=1. This overrides any sign adjustment.
  - Signed overflow (most negative value / -1): quot = most negative value, rem = 0, div0=0. This falls out of the magnitude arithmetic; no special case is needed.
- Unsigned build: no sign handling; the magnitude equals the operand.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken on capture.
  - FIX applies the sign rules above.
- Undefined: operands are unsigned.
  - FIX only registers Q/R and applies the divide-by-zero override.
  - No sign logic is synthesised.
- Latency and interface are identical in both builds.

Test Plan:
- 100/7, start on edge k -> valid=1 only in cycle after edge k+33 (WIDTH=32); quot=14, rem=2, div0=0; busy high edges k..k+32.
- Signed build: 0xFFFFFF9C/7 (-100/7) -> quot=0xFFFFFFF2, rem=0xFFFFFFFE. Unsigned build, same operands -> quot=0x24924916, rem=2.
- 5/0 -> quot=0xFFFFFFFF, rem=5, div0=1; latency unchanged. Signed build, 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0, div0=0.
- start held high during CALC with new operands -> ignored, first result unaffected. start=1 in DONE with 9/2 -> re-enters CALC; quot=4, rem=1 exactly 34 cycles after the first valid.
- reset_n pulsed low mid-CALC -> all outputs 0 immediately (asynchronous); no valid until a new start; next division 0xFFFFFFFF/0x10 (unsigned) -> quot=0x0FFFFFFF, rem=0xF.
